// File: rtl/alu_op_sequencer.sv
// Operation sequencer that sweeps enabled ALU select codes across a fixed operand table.
// It supports dwell timing, pause/single-step, abort and mask-error reporting.
module alu_op_sequencer #(
  parameter int unsigned DWELL = 1,
  parameter int unsigned NVEC  = 4
) (
  input  logic               clk_sel,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic               step,
  input  logic [15:0]        op_mask,
  output logic signed [3:0]  a,
  output logic signed [3:0]  b,
  output logic [3:0]         sel,
  output logic [1:0]         vec_idx,
  output logic               op_valid,
  output logic               busy,
  output logic               done,
  output logic               mask_err,
  output logic [7:0]         op_count
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic [7:0]        dwell_q, dwell_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        vec_q, vec_d;
  logic              op_valid_q, op_valid_d;
  logic              mask_err_q, mask_err_d;
  logic [7:0]        op_count_q, op_count_d;
  logic signed [3:0] a_q, a_d, b_q, b_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic       start_rise, has_en, has_higher, wrap_last, dwell_hit;
  logic [3:0] lowest_en, higher_en;
  logic       launch_ok, launch_bad, advance;

  assign start_rise = start & ~start_q;
  assign wrap_last  = (32'(vec_q) >= NVEC - 1);
  assign dwell_hit  = (32'(dwell_q) >= DWELL - 1);
  assign has_en     = |op_mask;

  // Descending scan: the last hit written is the lowest qualifying index.
  always_comb begin
    lowest_en  = 4'd0;
    higher_en  = 4'd0;
    has_higher = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (op_mask[i]) begin
        lowest_en = 4'(i);
        if (4'(i) > sel_q) begin
          higher_en  = 4'(i);
          has_higher = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk_sel or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; priority abort > launch > pause > step > dwell advance
  always_comb begin
    state_d    = state_q;
    launch_ok  = 1'b0;
    launch_bad = 1'b0;
    advance    = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else if ((state_q == StIdle || state_q == StDone) && start_rise) begin
      if (has_en) begin
        state_d   = StRun;
        launch_ok = 1'b1;
      end else begin
        state_d    = StIdle;
        launch_bad = 1'b1;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (pause) begin
            state_d = StPause;
          end else if (dwell_hit) begin
            advance = 1'b1;
          end
        end
        StPause: begin
          if (!pause) begin
            state_d = StRun;
          end else if (step) begin
            advance = 1'b1;
          end
        end
        default: ;
      endcase
      if (advance && (!has_en || (!has_higher && wrap_last))) begin
        state_d = StDone;
      end
    end
  end

  // Output / datapath next values
  always_comb begin
    dwell_d    = dwell_q;
    sel_d      = sel_q;
    vec_d      = vec_q;
    op_valid_d = op_valid_q;
    mask_err_d = mask_err_q;
    op_count_d = op_count_q;
    if (abort) begin
      dwell_d    = 8'd0;
      sel_d      = 4'd0;
      vec_d      = 2'd0;
      op_valid_d = 1'b0;
    end else if (launch_ok) begin
      dwell_d    = 8'd0;
      sel_d      = lowest_en;
      vec_d      = 2'd0;
      op_valid_d = 1'b1;
      mask_err_d = 1'b0;
      op_count_d = 8'd1;
    end else if (launch_bad) begin
      dwell_d    = 8'd0;
      sel_d      = 4'd0;
      vec_d      = 2'd0;
      op_valid_d = 1'b0;
      mask_err_d = 1'b1;
    end else if (advance) begin
      dwell_d = 8'd0;
      if (!has_en) begin
        op_valid_d = 1'b0;
        mask_err_d = 1'b1;
      end else if (has_higher || !wrap_last) begin
        if (has_higher) begin
          sel_d = higher_en;
        end else begin
          sel_d = lowest_en;
          vec_d = vec_q + 2'd1;
        end
        op_valid_d = 1'b1;
        op_count_d = (op_count_q == 8'hFF) ? 8'hFF : op_count_q + 8'd1;
      end else begin
        // Terminal wrap: selection and operands stay on the last operation.
        op_valid_d = 1'b0;
      end
    end else if (state_q == StRun && !pause) begin
      dwell_d = dwell_q + 8'd1;
    end

    a_d = 4'b0000;
    b_d = 4'b0000;
    if (state_d != StIdle) begin
      unique case (vec_d)
        2'd0: begin a_d = 4'b0100; b_d = 4'b1000; end
        2'd1: begin a_d = 4'b0111; b_d = 4'b0111; end
        2'd2: begin a_d = 4'b1111; b_d = 4'b0001; end
        default: begin a_d = 4'b0000; b_d = 4'b1000; end
      endcase
    end
    busy_d = (state_d == StRun) || (state_d == StPause);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_sel or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      dwell_q    <= 8'd0;
      sel_q      <= 4'd0;
      vec_q      <= 2'd0;
      op_valid_q <= 1'b0;
      mask_err_q <= 1'b0;
      op_count_q <= 8'd0;
      a_q        <= 4'sd0;
      b_q        <= 4'sd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q    <= start;
      dwell_q    <= dwell_d;
      sel_q      <= sel_d;
      vec_q      <= vec_d;
      op_valid_q <= op_valid_d;
      mask_err_q <= mask_err_d;
      op_count_q <= op_count_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign sel      = sel_q;
  assign vec_idx  = vec_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mask_err = mask_err_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with DWELL=1 and one with DWELL=2,
// both driven by the same stimulus.
module tb_alu_op_sequencer;

  logic        clk_sel = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic        pause   = 1'b0;
  logic        step    = 1'b0;
  logic [15:0] op_mask = 16'h0000;

  logic [3:0] a1, b1, sel1, a2, b2, sel2;
  logic [1:0] vec1, vec2;
  logic       valid1, busy1, done1, merr1, valid2, busy2, done2, merr2;
  logic [7:0] cnt1, cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sel = ~clk_sel;

  alu_op_sequencer #(.DWELL(1), .NVEC(4)) u_dut1 (
    .clk_sel(clk_sel), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .step(step), .op_mask(op_mask), .a(a1), .b(b1), .sel(sel1), .vec_idx(vec1),
    .op_valid(valid1), .busy(busy1), .done(done1), .mask_err(merr1), .op_count(cnt1)
  );

  alu_op_sequencer #(.DWELL(2), .NVEC(4)) u_dut2 (
    .clk_sel(clk_sel), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .step(step), .op_mask(op_mask), .a(a2), .b(b2), .sel(sel2), .vec_idx(vec2),
    .op_valid(valid2), .busy(busy2), .done(done2), .mask_err(merr2), .op_count(cnt2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_sel);
    #1;
  endtask

  logic [3:0] exp_sel2 [6];
  logic [1:0] exp_vec2 [6];

  initial begin
    exp_sel2 = '{4'd0, 4'd0, 4'd2, 4'd2, 4'd0, 4'd0};
    exp_vec2 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};

    // Reset state
    #2;
    check("rst_sel", 16'(sel1), 16'd0);
    check("rst_ab", {8'd0, a1, b1}, 16'd0);
    check("rst_flags", {12'd0, valid1, busy1, done1, merr1}, 16'd0);
    check("rst_cnt", 16'(cnt1), 16'd0);
    repeat (2) @(posedge clk_sel);
    #1 rst_n = 1'b1;
    tick();

    // Full sweep, mask FFFF, DWELL=1
    op_mask = 16'hFFFF;
    start   = 1'b1;
    tick();
    check("e1_sel", 16'(sel1), 16'd0);
    check("e1_ab", {8'd0, a1, b1}, 16'h0048);
    check("e1_flags", {12'd0, valid1, busy1, done1, merr1}, 16'b1100);
    check("e1_cnt", 16'(cnt1), 16'd1);
    repeat (15) tick();
    check("e16_sel", 16'(sel1), 16'd15);
    tick();
    check("e17_sel", 16'(sel1), 16'd0);
    check("e17_vec", 16'(vec1), 16'd1);
    check("e17_ab", {8'd0, a1, b1}, 16'h0077);
    repeat (47) tick();
    check("e64_cnt", 16'(cnt1), 16'd64);
    check("e64_busy", 16'(busy1), 16'd1);
    tick();
    check("done_flags", {12'd0, valid1, busy1, done1, merr1}, 16'b0010);
    check("done_cnt", 16'(cnt1), 16'd64);
    check("done_sel", 16'(sel1), 16'd15);
    check("done_vec", 16'(vec1), 16'd3);
    check("done_ab", {8'd0, a1, b1}, 16'h0008);
    tick();
    check("done_hold", 16'(done1), 16'd1);

    // Abort from DONE
    abort = 1'b1;
    tick();
    check("abort_flags", {12'd0, valid1, busy1, done1, merr1}, 16'b0000);
    check("abort_cnt", 16'(cnt1), 16'd64);
    check("abort_ab", {4'd0, a1, b1, sel1}, 16'd0);
    abort = 1'b0;
    start = 1'b0;
    tick();

    // Sparse mask 0005: DWELL=2 instance sweeps 0,0,2,2,0,0...
    op_mask = 16'h0005;
    start   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("d2_sel%0d", i), 16'(sel2), 16'(exp_sel2[i]));
      check($sformatf("d2_vec%0d", i), 16'(vec2), 16'(exp_vec2[i]));
      if (i == 1) check("d1_sparse_sel", 16'(sel1), 16'd2);
      if (i == 2) check("d1_sparse_vec", 16'(vec1), 16'd1);
    end
    repeat (10) tick();
    check("d2_e16_done", 16'(done2), 16'd0);
    check("d2_e16_cnt", 16'(cnt2), 16'd8);
    tick();
    check("d2_done", 16'(done2), 16'd1);
    check("d2_done_cnt", 16'(cnt2), 16'd8);
    check("d2_done_sel", 16'(sel2), 16'd2);
    abort = 1'b1;
    start = 1'b0;
    tick();
    abort   = 1'b0;
    op_mask = 16'hFFFF;
    tick();

    // Pause / step / resume
    start = 1'b1;
    tick();
    repeat (3) tick();
    check("p_sel3", 16'(sel1), 16'd3);
    pause = 1'b1;
    repeat (10) tick();
    check("p_hold_sel", 16'(sel1), 16'd3);
    check("p_hold_flags", {12'd0, valid1, busy1, done1, merr1}, 16'b1100);
    step = 1'b1;
    repeat (2) tick();
    check("p_step_sel", 16'(sel1), 16'd5);
    step  = 1'b0;
    pause = 1'b0;
    tick();
    check("p_resume_sel", 16'(sel1), 16'd5);
    tick();
    check("p_run_sel", 16'(sel1), 16'd6);
    check("p_cnt", 16'(cnt1), 16'd7);

    // Mask cleared mid-run
    op_mask = 16'h0000;
    tick();
    check("mclr_flags", {12'd0, valid1, busy1, done1, merr1}, 16'b0011);
    check("mclr_cnt", 16'(cnt1), 16'd7);
    abort = 1'b1;
    start = 1'b0;
    tick();
    abort = 1'b0;
    tick();

    // Launch attempt with empty mask
    start = 1'b1;
    tick();
    check("m0_flags", {12'd0, valid1, busy1, done1, merr1}, 16'b0001);
    check("m0_cnt", 16'(cnt1), 16'd7);

    // Abort coinciding with a start rise
    start = 1'b0;
    tick();
    op_mask = 16'hFFFF;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    check("ab_rise_flags", {12'd0, valid1, busy1, done1, merr1}, 16'b0001);
    check("ab_rise_cnt", 16'(cnt1), 16'd7);
    abort = 1'b0;
    tick();
    check("no_rise_busy", 16'(busy1), 16'd0);

    // Asynchronous reset mid-run at sel=9
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("r_launch", {7'd0, cnt1, merr1}, {7'd0, 8'd1, 1'b0});
    repeat (9) tick();
    check("r_sel9", 16'(sel1), 16'd9);
    #2 rst_n = 1'b0;
    #1;
    check("r_async_ab", {4'd0, a1, b1, sel1}, 16'd0);
    check("r_async_flags", {12'd0, valid1, busy1, done1, merr1}, 16'd0);
    check("r_async_cnt", {6'd0, vec1, cnt1}, 16'd0);
    start = 1'b0;
    @(posedge clk_sel);
    #1 rst_n = 1'b1;
    tick();
    check("r_after_busy", 16'(busy1), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
